// File: rtl/pack_bit_pkg.sv
// pack_bit_pkg: shared widths for the 2-bit symbol to 16-bit word packer.
package pack_bit_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_SYM_W  = 2;
  localparam int PAIRS      = DEF_DATA_W / DEF_SYM_W;
  localparam int CNT_W      = $clog2(PAIRS);
  localparam int LEN_W      = 4;

endpackage

// File: rtl/pack_bit_out_reg.sv
// pack_bit_out_reg: single-entry output holding register with valid/ready.
// Holds one word plus its pair count; o_free says a new word may load now.
module pack_bit_out_reg
  import pack_bit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [LEN_W-1:0]  o_len,
  output logic              o_free
);

  // Register is free when empty or being drained this cycle.
  assign o_free = !o_valid || i_ready;

  // Load a new word, or drop valid once the consumer takes the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_len   <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
      o_len   <= i_len;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pack_bit.sv
// pack_bit: packs 2-bit symbols MSB-first into 16-bit words.
// Optional partial-word flush is enabled by defining PACK_BIT_FLUSH_EN;
// without it i_flush is ignored and only full words are emitted.
module pack_bit
  import pack_bit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SYM_W  = DEF_SYM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [SYM_W-1:0]  i_rx,
  output logic              o_ready,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [LEN_W-1:0]  o_len,
  input  logic              i_ready
);

  localparam int NP  = DATA_W / SYM_W;
  localparam int CW  = $clog2(NP);
  localparam int AW  = DATA_W - SYM_W;

  logic [AW-1:0]     r_asm;
  logic [CW-1:0]     r_cnt;

  logic              w_free;
  logic              w_last;
  logic              w_acc;
  logic              w_pend_blk;
  logic [AW-1:0]     w_asm_app;
  logic [CW-1:0]     w_cnt_app;
  logic [AW-1:0]     w_asm_n;
  logic [CW-1:0]     w_cnt_n;
  logic              w_load;
  logic [DATA_W-1:0] w_ld_data;
  logic [LEN_W-1:0]  w_ld_len;
  logic [DATA_W-1:0] w_left;

  // Seven pairs already held: the next pair completes a word.
  assign w_last = (r_cnt == CW'(NP - 1));

`ifdef PACK_BIT_FLUSH_EN
  logic r_flush_pend;
  logic w_pend_n;
  assign w_pend_blk = r_flush_pend;
`else
  logic w_unused_flush;
  assign w_unused_flush = i_flush;
  assign w_pend_blk     = 1'b0;
`endif

  // Stall only the completing pair when the output cannot take its word,
  // and stall everything while a flush waits for the output register.
  assign o_ready = !(w_last && o_valid && !i_ready) && !w_pend_blk;
  assign w_acc   = i_valid && o_ready;

  // Append, word completion and flush decisions for the next cycle.
  always_comb begin
    w_asm_app = r_asm;
    w_cnt_app = r_cnt;
    w_asm_n   = r_asm;
    w_cnt_n   = r_cnt;
    w_load    = 1'b0;
    w_ld_data = '0;
    w_ld_len  = '0;
    w_left    = '0;
`ifdef PACK_BIT_FLUSH_EN
    w_pend_n  = r_flush_pend;
`endif
    if (w_acc && w_last) begin
      // Completing pair: emit the full word; a coincident flush is consumed.
      w_load    = 1'b1;
      w_ld_data = {r_asm, i_rx};
      w_ld_len  = LEN_W'(NP);
      w_asm_n   = '0;
      w_cnt_n   = '0;
`ifdef PACK_BIT_FLUSH_EN
      w_pend_n  = 1'b0;
`endif
    end else begin
      if (w_acc) begin
        w_asm_app = {r_asm[AW-SYM_W-1:0], i_rx};
        w_cnt_app = r_cnt + CW'(1);
      end
      w_asm_n = w_asm_app;
      w_cnt_n = w_cnt_app;
`ifdef PACK_BIT_FLUSH_EN
      // Flush sees the pair appended this cycle; empty assembly is ignored.
      if ((i_flush || r_flush_pend) && (w_cnt_app != '0)) begin
        if (w_free) begin
          w_left    = {w_asm_app, {SYM_W{1'b0}}};
          w_load    = 1'b1;
          w_ld_data = w_left << (SYM_W * (NP - 1 - int'(w_cnt_app)));
          w_ld_len  = LEN_W'(w_cnt_app);
          w_asm_n   = '0;
          w_cnt_n   = '0;
          w_pend_n  = 1'b0;
        end else begin
          w_pend_n  = 1'b1;
        end
      end
`endif
    end
  end

  // Assembly register, pair count and pending-flush state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_asm <= '0;
      r_cnt <= '0;
`ifdef PACK_BIT_FLUSH_EN
      r_flush_pend <= 1'b0;
`endif
    end else begin
      r_asm <= w_asm_n;
      r_cnt <= w_cnt_n;
`ifdef PACK_BIT_FLUSH_EN
      r_flush_pend <= w_pend_n;
`endif
    end
  end

  pack_bit_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_ld_data),
    .i_len   (w_ld_len),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_len   (o_len),
    .o_free  (w_free)
  );

endmodule
